// File: rtl/tensor_core_rf_controller.sv
// Command sequencer owning the tensor core register file control pins and start/done handshake.
// Optional compute-cycle counter enabled by defining TC_PERF_COUNTER_EN.
module tensor_core_rf_controller #(
  parameter int NUMBER_OF_REGISTERS = 32,
  parameter int DATA_WIDTH          = 8,
  parameter int COMPUTE_TIMEOUT     = 255,
  parameter int AW                  = $clog2(NUMBER_OF_REGISTERS)
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic                  cmd_valid_in,
  output logic                  cmd_ready_out,
  input  logic [1:0]            cmd_opcode_in,
  input  logic [AW-1:0]         cmd_base_in,
  input  logic [AW-1:0]         cmd_count_in,
  input  logic                  load_data_valid_in,
  output logic                  load_data_ready_out,
  input  logic [DATA_WIDTH-1:0] load_data_in,
  output logic                  read_data_valid_out,
  input  logic                  read_data_ready_in,
  output logic [DATA_WIDTH-1:0] read_data_out,
  output logic                  rf_non_bulk_write_enable_out,
  output logic [AW-1:0]         rf_non_bulk_write_register_address_out,
  output logic [DATA_WIDTH-1:0] rf_non_bulk_write_data_out,
  output logic [AW-1:0]         rf_non_bulk_read_register_address_out,
  input  logic [DATA_WIDTH-1:0] rf_non_bulk_read_data_in,
  output logic                  rf_bulk_write_enable_out,
  output logic                  rf_reset_out,
  output logic                  tc_start_out,
  input  logic                  tc_done_in,
  output logic                  busy_out,
  output logic                  error_out,
  output logic [15:0]           compute_cycles_out
);
  localparam int TW = $clog2(COMPUTE_TIMEOUT + 1);
  localparam logic [AW:0]   NREG     = (AW+1)'(NUMBER_OF_REGISTERS);
  localparam logic [TW-1:0] TMO_LAST = TW'(COMPUTE_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_TC_START, S_TC_WAIT, S_CLEAR} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_COMPUTE, OP_READ, OP_CLEAR} op_t;
  typedef struct packed {
    logic [AW-1:0] base;
    logic [AW:0]   len;
  } cmd_t;

  state_t        state;
  cmd_t          cmd_q;
  logic [AW:0]   idx;
  logic [TW-1:0] wait_cnt;
  logic          started_q;
  logic          err_q;

  logic [AW:0]   sum, addr_full, cmd_len;
  logic          cmd_fire, load_fire, read_fire, last_beat, done_fire;

  // Address wraps modulo the file depth, which need not be a power of two.
  assign sum       = {1'b0, cmd_q.base} + idx;
  assign addr_full = (sum >= NREG) ? sum - NREG : sum;
  assign cmd_len   = (cmd_count_in == '0) ? NREG : {1'b0, cmd_count_in};
  assign last_beat = (idx == cmd_q.len - 1'b1);

  assign cmd_ready_out = started_q && (state == S_IDLE);
  assign cmd_fire      = cmd_valid_in && cmd_ready_out;
  assign load_fire     = (state == S_LOAD) && load_data_valid_in;
  assign read_fire     = (state == S_READ) && read_data_ready_in;
  assign done_fire     = (state == S_TC_WAIT) && tc_done_in;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state     <= S_IDLE;
      cmd_q     <= '0;
      idx       <= '0;
      wait_cnt  <= '0;
      started_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      started_q <= 1'b1;
      case (state)
        S_IDLE: if (cmd_fire) begin
          cmd_q.base <= cmd_base_in;
          cmd_q.len  <= cmd_len;
          idx        <= '0;
          case (op_t'(cmd_opcode_in))
            OP_LOAD:    state <= S_LOAD;
            OP_COMPUTE: state <= S_TC_START;
            OP_READ:    state <= S_READ;
            OP_CLEAR:   state <= S_CLEAR;
          endcase
        end
        S_LOAD: if (load_fire) begin
          idx <= idx + 1'b1;
          if (last_beat) state <= S_IDLE;
        end
        S_READ: if (read_fire) begin
          idx <= idx + 1'b1;
          if (last_beat) state <= S_IDLE;
        end
        S_TC_START: begin
          wait_cnt <= '0;
          state    <= S_TC_WAIT;
        end
        S_TC_WAIT: begin
          if (tc_done_in) state <= S_IDLE;
          else if (wait_cnt == TMO_LAST) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else wait_cnt <= wait_cnt + 1'b1;
        end
        S_CLEAR: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign load_data_ready_out                    = (state == S_LOAD);
  assign rf_non_bulk_write_enable_out           = load_fire;
  assign rf_non_bulk_write_register_address_out = addr_full[AW-1:0];
  assign rf_non_bulk_write_data_out             = load_fire ? load_data_in : '0;
  assign rf_non_bulk_read_register_address_out  = addr_full[AW-1:0];
  assign read_data_valid_out                    = (state == S_READ);
  assign read_data_out = (state == S_READ) ? rf_non_bulk_read_data_in : '0;
  assign rf_bulk_write_enable_out               = done_fire;
  assign rf_reset_out                           = (state == S_CLEAR);
  assign tc_start_out                           = (state == S_TC_START);
  assign busy_out                               = (state != S_IDLE);
  assign error_out                              = err_q;

`ifdef TC_PERF_COUNTER_EN
  logic [15:0] perf_q;
  logic [16:0] done_cycles;
  // Start-to-done distance includes the done cycle itself.
  assign done_cycles = 17'(wait_cnt) + 17'd1;
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) perf_q <= '0;
    else if (done_fire) perf_q <= done_cycles[16] ? 16'hFFFF : done_cycles[15:0];
  end
  assign compute_cycles_out = perf_q;
`else
  assign compute_cycles_out = '0;
`endif
endmodule

// File: tb/tb_tensor_core_rf_controller.sv
// Directed bench for tensor_core_rf_controller with a behavioural register file.
module tb_tensor_core_rf_controller;
  logic       clock_in = 1'b0;
  logic       reset_n_in;
  logic       cmd_valid_in, cmd_ready_out;
  logic [1:0] cmd_opcode_in;
  logic [4:0] cmd_base_in, cmd_count_in;
  logic       load_data_valid_in, load_data_ready_out;
  logic [7:0] load_data_in;
  logic       read_data_valid_out, read_data_ready_in;
  logic [7:0] read_data_out;
  logic       we;
  logic [4:0] waddr, raddr;
  logic [7:0] wdata, rdata;
  logic       bulk, rf_rst, tc_start_out, tc_done_in, busy_out, error_out;
  logic [15:0] compute_cycles_out;

`ifdef TC_PERF_COUNTER_EN
  localparam logic [15:0] EXP_CC = 16'd7;
`else
  localparam logic [15:0] EXP_CC = 16'd0;
`endif

  tensor_core_rf_controller dut (
    .clock_in(clock_in), .reset_n_in(reset_n_in),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_opcode_in(cmd_opcode_in), .cmd_base_in(cmd_base_in), .cmd_count_in(cmd_count_in),
    .load_data_valid_in(load_data_valid_in), .load_data_ready_out(load_data_ready_out),
    .load_data_in(load_data_in),
    .read_data_valid_out(read_data_valid_out), .read_data_ready_in(read_data_ready_in),
    .read_data_out(read_data_out),
    .rf_non_bulk_write_enable_out(we), .rf_non_bulk_write_register_address_out(waddr),
    .rf_non_bulk_write_data_out(wdata), .rf_non_bulk_read_register_address_out(raddr),
    .rf_non_bulk_read_data_in(rdata), .rf_bulk_write_enable_out(bulk),
    .rf_reset_out(rf_rst), .tc_start_out(tc_start_out), .tc_done_in(tc_done_in),
    .busy_out(busy_out), .error_out(error_out), .compute_cycles_out(compute_cycles_out)
  );

  always #5 clock_in = ~clock_in;

  // Behavioural register file: contents start as rf[i] = i.
  logic [7:0] rf [32];
  logic       rf_up = 1'b0;
  int n_start = 0, n_bulk = 0, n_rst = 0, n_overlap = 0;
  always @(posedge clock_in) begin
    if (!rf_up) begin
      for (int i = 0; i < 32; i++) rf[i] <= 8'(i);
      rf_up <= 1'b1;
    end else if (rf_rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 8'd0;
    end else if (we) rf[waddr] <= wdata;
    if (tc_start_out) n_start <= n_start + 1;
    if (bulk)         n_bulk  <= n_bulk + 1;
    if (rf_rst)       n_rst   <= n_rst + 1;
  end
  assign rdata = rf[raddr];

  always @(negedge clock_in)
    if (reset_n_in && (32'(we) + 32'(bulk) + 32'(tc_start_out) + 32'(rf_rst) > 1))
      n_overlap <= n_overlap + 1;

  int checks = 0, failures = 0;
  logic [7:0] exp_rf [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] base, input logic [4:0] cnt);
    int n = 0;
    @(negedge clock_in);
    cmd_valid_in = 1; cmd_opcode_in = op; cmd_base_in = base; cmd_count_in = cnt;
    #1;
    while (!cmd_ready_out && n < 400) begin @(negedge clock_in); #1; n++; end
    chk("cmd_accept", cmd_ready_out, 1);
    @(posedge clock_in); #1 cmd_valid_in = 0;
  endtask

  task automatic load_beat(input logic [7:0] d, input logic [4:0] a);
    @(negedge clock_in);
    load_data_valid_in = 1; load_data_in = d; #1;
    chk("load_ready", load_data_ready_out, 1);
    chk("load_we", we, 1);
    chk("load_addr", waddr, a);
    chk("load_data", wdata, d);
    @(posedge clock_in); #1 load_data_valid_in = 0;
    exp_rf[a] = d;
  endtask

  task automatic read_beat(input logic [4:0] a);
    @(negedge clock_in);
    read_data_ready_in = 1; #1;
    chk("read_valid", read_data_valid_out, 1);
    chk("read_addr", raddr, a);
    chk("read_data", read_data_out, exp_rf[a]);
    @(posedge clock_in); #1 read_data_ready_in = 0;
  endtask

  task automatic idle_chk(input string name);
    @(negedge clock_in); #1;
    chk({name, "_ready"}, cmd_ready_out, 1);
    chk({name, "_busy"}, busy_out, 0);
  endtask

  typedef struct {
    logic [4:0] base;
    logic [4:0] count;
    int         beats;
    logic [4:0] last_addr;
    logic [7:0] d0;
  } load_vec_t;
  load_vec_t vt [4];

  initial begin
    int s0, s1, n;
    logic [4:0] a;
    reset_n_in = 0; cmd_valid_in = 0; cmd_opcode_in = 0; cmd_base_in = 0; cmd_count_in = 0;
    load_data_valid_in = 0; load_data_in = 0; read_data_ready_in = 0; tc_done_in = 0;
    for (int i = 0; i < 32; i++) exp_rf[i] = 8'(i);
    vt[0] = '{5'd5,  5'd1, 1, 5'd5,  8'h50};
    vt[1] = '{5'd31, 5'd2, 2, 5'd0,  8'h60};
    vt[2] = '{5'd12, 5'd3, 3, 5'd14, 8'h70};
    vt[3] = '{5'd28, 5'd6, 6, 5'd1,  8'h80};

    repeat (2) @(negedge clock_in); #1;
    chk("rst_cmd_ready", cmd_ready_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_load_ready", load_data_ready_out, 0);
    chk("rst_read_valid", read_data_valid_out, 0);
    chk("rst_pins", {we, bulk, rf_rst, tc_start_out, error_out}, 0);
    chk("rst_addr", {waddr, raddr, wdata}, 0);
    chk("rst_cycles", compute_cycles_out, 0);
    @(negedge clock_in) reset_n_in = 1;
    @(posedge clock_in); #1;
    chk("first_clk_ready", cmd_ready_out, 1);

    // Table of LOAD commands, including wrap past the top register.
    for (int r = 0; r < 4; r++) begin
      send_cmd(2'd0, vt[r].base, vt[r].count);
      for (int j = 0; j < vt[r].beats; j++) begin
        a = (j == vt[r].beats - 1) ? vt[r].last_addr : vt[r].base + 5'(j);
        load_beat(vt[r].d0 + 8'(j), a);
      end
      idle_chk("tbl_done");
    end

    // LOAD base=30 count=4 with a two-cycle gap between beats 2 and 3.
    send_cmd(2'd0, 5'd30, 5'd4);
    load_beat(8'd11, 5'd30);
    load_beat(8'd22, 5'd31);
    repeat (2) begin
      @(negedge clock_in); #1;
      chk("gap_no_we", we, 0);
      chk("gap_ready", load_data_ready_out, 1);
    end
    load_beat(8'd33, 5'd0);
    load_beat(8'd44, 5'd1);
    idle_chk("load4_done");

    // Full-depth READ with a three-cycle stall before beat 5.
    send_cmd(2'd2, 5'd0, 5'd0);
    for (int j = 0; j < 32; j++) begin
      if (j == 4) repeat (3) begin
        @(negedge clock_in); #1;
        chk("stall_valid", read_data_valid_out, 1);
        chk("stall_addr", raddr, 4);
        chk("stall_data", read_data_out, exp_rf[4]);
      end
      read_beat(5'(j));
    end
    idle_chk("read32_done");

    // COMPUTE with done seven cycles after start.
    s0 = n_start; s1 = n_bulk;
    send_cmd(2'd1, 5'd0, 5'd0);
    @(negedge clock_in); #1;
    chk("start_pulse", tc_start_out, 1);
    repeat (6) begin
      @(negedge clock_in); #1;
      chk("wait_no_bulk", bulk, 0);
      chk("wait_no_start", tc_start_out, 0);
    end
    @(negedge clock_in) tc_done_in = 1; #1;
    chk("done_bulk", bulk, 1);
    @(posedge clock_in); #1 tc_done_in = 0;
    @(negedge clock_in); #1;
    chk("compute_idle", busy_out, 0);
    chk("compute_cycles", compute_cycles_out, EXP_CC);
    chk("compute_err", error_out, 0);
    chk("start_count", n_start - s0, 1);
    chk("bulk_count", n_bulk - s1, 1);

    // done in IDLE is ignored
    s1 = n_bulk;
    @(negedge clock_in) tc_done_in = 1; #1;
    chk("idle_done_bulk", bulk, 0);
    @(posedge clock_in); #1 tc_done_in = 0;
    @(negedge clock_in); #1;
    chk("idle_done_busy", busy_out, 0);
    chk("idle_done_count", n_bulk - s1, 0);

    // COMPUTE timeout then CLEAR
    send_cmd(2'd1, 5'd0, 5'd0);
    @(negedge clock_in); #1;
    chk("tmo_start", tc_start_out, 1);
    repeat (255) @(negedge clock_in); #1;
    chk("tmo_not_yet_err", error_out, 0);
    chk("tmo_not_yet_busy", busy_out, 1);
    @(negedge clock_in); #1;
    chk("tmo_err", error_out, 1);
    chk("tmo_idle", busy_out, 0);
    chk("tmo_no_bulk", n_bulk - s1, 0);
    chk("tmo_cycles_kept", compute_cycles_out, EXP_CC);
    s0 = n_rst;
    send_cmd(2'd3, 5'd0, 5'd0);
    @(negedge clock_in); #1;
    chk("clear_pulse", rf_rst, 1);
    @(negedge clock_in); #1;
    chk("clear_once", rf_rst, 0);
    chk("clear_err", error_out, 0);
    chk("clear_count", n_rst - s0, 1);
    for (int i = 0; i < 32; i++) exp_rf[i] = 8'd0;

    // cmd_valid held high through a LOAD; the queued CLEAR waits for IDLE.
    s0 = n_rst;
    @(negedge clock_in);
    cmd_valid_in = 1; cmd_opcode_in = 2'd0; cmd_base_in = 5'd8; cmd_count_in = 5'd2;
    @(posedge clock_in); #1 cmd_opcode_in = 2'd3;
    @(negedge clock_in); #1;
    chk("held_ready_load", cmd_ready_out, 0);
    load_beat(8'h91, 5'd8);
    load_beat(8'h92, 5'd9);
    chk("held_no_clear", n_rst - s0, 0);
    @(negedge clock_in); #1;
    chk("held_ready_idle", cmd_ready_out, 1);
    @(posedge clock_in); #1 cmd_valid_in = 0;
    @(negedge clock_in); #1;
    chk("held_clear", rf_rst, 1);
    for (int i = 0; i < 32; i++) exp_rf[i] = 8'd0;

    // Reset mid-LOAD at beat 2 of 8.
    send_cmd(2'd0, 5'd16, 5'd8);
    load_beat(8'hA1, 5'd16);
    @(negedge clock_in);
    load_data_valid_in = 1; load_data_in = 8'hA2; #1;
    reset_n_in = 0; #1;
    chk("arst_we", we, 0);
    chk("arst_wdata", {waddr, wdata}, 0);
    chk("arst_streams", {load_data_ready_out, read_data_valid_out}, 0);
    chk("arst_status", {busy_out, cmd_ready_out, error_out}, 0);
    @(negedge clock_in) load_data_valid_in = 0;
    @(negedge clock_in) reset_n_in = 1;
    @(posedge clock_in); #1;
    chk("arst_release_ready", cmd_ready_out, 1);
    send_cmd(2'd0, 5'd20, 5'd2);
    load_beat(8'hB1, 5'd20);
    load_beat(8'hB2, 5'd21);
    idle_chk("reload_done");

    // Read back 16..21: 17..19 must still hold the cleared value.
    send_cmd(2'd2, 5'd16, 5'd6);
    for (int j = 0; j < 6; j++) read_beat(5'd16 + 5'(j));
    n = 0;
    idle_chk("final_read");
    chk("exclusive_pins", n_overlap, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
